// File: rtl/int_branch_resolver.sv
// int_branch_resolver
//   Picks the oldest mispredicted branch among the integer lanes. That branch
//   is presented to the recovery manager as a req/ack/done handshake. A
//   deferred slot holds the oldest older-than-in-flight mispredict that
//   arrives during a flush. The block also emits registered per-lane
//   branch-predictor update records.
// Ports:
//   clk, rst                    clock, async active-high reset
//   stall, clear                squash all lane inputs when set
//   al_head_ptr                 active-list head (age origin)
//   in_*                        per-lane branch results from integer execute
//   recov_req/al_ptr/target     recovery request and its payload
//   recov_ack, recov_done       handshake from the recovery manager
//   bp_upd_*                    registered predictor update records
//   busy                        FSM not idle
//
// state | meaning
// IDLE  | no recovery outstanding
// REQ   | recov_req high, payload may still be replaced by an older branch
// FLUSH | request accepted, waiting for flush of younger ops to finish
module int_branch_resolver #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int AL_PTR_WIDTH = 6,
  parameter int PC_WIDTH     = 32,
  parameter int GHIST_WIDTH  = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic                              clear,
  input  logic [AL_PTR_WIDTH-1:0]           al_head_ptr,
  input  logic [ISSUE_WIDTH-1:0]            in_valid,
  input  logic [ISSUE_WIDTH-1:0]            in_br_valid,
  input  logic [ISSUE_WIDTH-1:0]            in_mispred,
  input  logic [ISSUE_WIDTH-1:0]            in_exec_taken,
  input  logic [ISSUE_WIDTH-1:0]            in_is_cond,
  input  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0] in_al_ptr,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]   in_br_addr,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]   in_next_addr,
  input  logic [ISSUE_WIDTH*GHIST_WIDTH-1:0] in_ghist,
  output logic                              recov_req,
  output logic [AL_PTR_WIDTH-1:0]           recov_al_ptr,
  output logic [PC_WIDTH-1:0]               recov_target,
  input  logic                              recov_ack,
  input  logic                              recov_done,
  output logic [ISSUE_WIDTH-1:0]            bp_upd_valid,
  output logic [ISSUE_WIDTH-1:0]            bp_upd_taken,
  output logic [ISSUE_WIDTH*PC_WIDTH-1:0]   bp_upd_addr,
  output logic [ISSUE_WIDTH*GHIST_WIDTH-1:0] bp_upd_ghist,
  output logic                              busy
);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t                  state;
  logic                    def_valid;
  logic [AL_PTR_WIDTH-1:0] def_ptr;
  logic [PC_WIDTH-1:0]     def_target;

  logic [ISSUE_WIDTH-1:0]  cand;
  logic                    win_valid;
  logic [AL_PTR_WIDTH-1:0] win_ptr;
  logic [AL_PTR_WIDTH-1:0] win_age;
  logic [PC_WIDTH-1:0]     win_target;
  logic [AL_PTR_WIDTH-1:0] lane_ptr;
  logic [AL_PTR_WIDTH-1:0] lane_age;

  logic                    win_older;
  logic                    win_to_def;
  logic                    def_nxt_valid;
  logic [AL_PTR_WIDTH-1:0] def_nxt_ptr;
  logic [PC_WIDTH-1:0]     def_nxt_target;

  function automatic logic [AL_PTR_WIDTH-1:0] age_of(
    input logic [AL_PTR_WIDTH-1:0] p,
    input logic [AL_PTR_WIDTH-1:0] head
  );
    return p - head;  // wraps modulo 2^AL_PTR_WIDTH
  endfunction

  assign cand = in_valid & in_br_valid & in_mispred & {ISSUE_WIDTH{~stall & ~clear}};

  // Strict less-than keeps the lower lane on equal ages.
  always_comb begin
    win_valid  = 1'b0;
    win_ptr    = '0;
    win_age    = '0;
    win_target = '0;
    lane_ptr   = '0;
    lane_age   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lane_ptr = in_al_ptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
      lane_age = age_of(lane_ptr, al_head_ptr);
      if (cand[i] && (!win_valid || lane_age < win_age)) begin
        win_valid  = 1'b1;
        win_ptr    = lane_ptr;
        win_age    = lane_age;
        win_target = in_next_addr[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  assign win_older  = win_valid && (win_age < age_of(recov_al_ptr, al_head_ptr));
  assign win_to_def = win_older &&
                      (!def_valid || win_age < age_of(def_ptr, al_head_ptr));

  // Deferred slot as it would be after this cycle; lets a winner arriving in
  // the done cycle be picked up instead of lost.
  assign def_nxt_valid  = def_valid | win_to_def;
  assign def_nxt_ptr    = win_to_def ? win_ptr    : def_ptr;
  assign def_nxt_target = win_to_def ? win_target : def_target;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      recov_req    <= 1'b0;
      recov_al_ptr <= '0;
      recov_target <= '0;
      def_valid    <= 1'b0;
      def_ptr      <= '0;
      def_target   <= '0;
      bp_upd_valid <= '0;
      bp_upd_taken <= '0;
      bp_upd_addr  <= '0;
      bp_upd_ghist <= '0;
    end else begin
      bp_upd_valid <= in_valid & in_br_valid & {ISSUE_WIDTH{~stall & ~clear}};
      bp_upd_taken <= in_exec_taken;
      bp_upd_addr  <= in_br_addr;
      bp_upd_ghist <= in_ghist;

      case (state)
        IDLE: begin
          if (win_valid) begin
            recov_al_ptr <= win_ptr;
            recov_target <= win_target;
            recov_req    <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (recov_ack) begin
            // Ack covers the payload on the wire; an older winner in the same
            // cycle must wait in the deferred slot.
            recov_req <= 1'b0;
            state     <= FLUSH;
            if (win_to_def) begin
              def_valid  <= 1'b1;
              def_ptr    <= win_ptr;
              def_target <= win_target;
            end
          end else if (win_older) begin
            recov_al_ptr <= win_ptr;
            recov_target <= win_target;
          end
        end
        FLUSH: begin
          if (recov_done) begin
            def_valid <= 1'b0;
            if (def_nxt_valid) begin
              recov_al_ptr <= def_nxt_ptr;
              recov_target <= def_nxt_target;
              recov_req    <= 1'b1;
              state        <= REQ;
            end else begin
              state <= IDLE;
            end
          end else if (win_to_def) begin
            def_valid  <= 1'b1;
            def_ptr    <= win_ptr;
            def_target <= win_target;
          end
        end
        default: begin
          state     <= IDLE;
          recov_req <= 1'b0;
        end
      endcase
    end
  end

  // Conditional flag is not needed by the recovery path or the update record.
  logic unused_ok;
  assign unused_ok = ^in_is_cond;

endmodule
